ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the registered ID/EX fields (funct, shamt, operand_1, operand_2, reg_write_en, reg_write_addr) and produces the ALU result and write-back control for the EX/MEM register.
- Owns the HI/LO registers, a single-cycle multiplier and a 32-iteration restoring divider.
- Requests a pipeline stall while a divide is in progress.

Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles; fixed at the operand width, not meant to be overridden.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  cancels the instruction in EX (exception/eret).
- stall  in  1  EX is held by the pipeline controller this cycle.
- funct  in  6  MIPS funct code. ID maps I-type ALU ops onto R-type funct.
- shamt  in  5  shift amount for SLL/SRL/SRA.
- operand_1  in  32  rs value or immediate path.
- operand_2  in  32  rt value or immediate.
- reg_write_en_in  in  1  instruction writes the GPR file.
- reg_write_addr_in  in  5  destination GPR.
- result  out  32  ALU/shift/MF result.
- reg_write_en_out  out  1  GPR write enable after overflow masking.
- reg_write_addr_out  out  5  passthrough of reg_write_addr_in.
- overflow_flag  out  1  ADD/SUB signed overflow.
- stall_request  out  1  divider busy; controller must hold IF–EX.
- hi_out  out  32  current HI register.
- lo_out  out  32  current LO register.

Behaviour:
- Reset: HI=0, LO=0, divider state IDLE, counters/partials cleared. With all-zero inputs: result=0, overflow_flag=0, stall_request=0, reg_write_en_out=0.
- result, overflow_flag and stall_request are combinational from inputs and state; no added latency for non-divide ops.
- ALU funct codes:
  - 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x2A SLT (signed), 0x2B SLTU
  - 0x00 SLL, 0x02 SRL, 0x03 SRA use shamt.
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV use operand_1[4:0] as the amount and shift operand_2.
  - Unlisted funct: result=0.
- Overflow: raised on ADD/SUB only. While raised, reg_write_en_out=0; otherwise reg_write_en_out=reg_write_en_in.
- MF/MT:
  - MFHI 0x10 gives result=HI; MFLO 0x12 gives result=LO.
  - MTHI 0x11 sets HI<=operand_1; MTLO 0x13 sets LO<=operand_1.
- MULT 0x18 / MULTU 0x19: full 64-bit product in one cycle, signed/unsigned; {HI,LO}<=product.
- HI/LO commit rule: write at the clock edge only when stall=0 and flush=0. MFHI/MFLO in the following instruction therefore sees the new value. No HI/LO forwarding within a single cycle.
- Divider FSM, DIV 0x1A / DIVU 0x1B:
  - IDLE: on DIV/DIVU with flush=0, stall_request=1 combinationally. Latch |operands| and sign info; go to BUSY with count=0. If divisor=0, go to DONE directly.
  - BUSY: one restoring shift-subtract step per cycle; stall_request=1. After step DIV_CYCLES-1, go to DONE.
  - DONE: stall_request=0. For DIV, quotient negated if signs differ; remainder takes the dividend's sign. When stall=0, commit LO=quotient, HI=remainder and return to IDLE. If stall=1, remain in DONE and keep the result.
  - Total stall_request high time: 33 cycles for nonzero divisor, 1 cycle for a zero divisor.
- Divide by zero: LO=0xFFFFFFFF, HI=operand_1 (raw), no exception.
- flush in any state, or rst mid-divide: next state IDLE, no HI/LO write, stall_request=0 from the next cycle.
- stall=1 while IDLE with a non-divide op: no HI/LO change; combinational result still presented.
- A DIV following a DIV starts only after the first reaches DONE and commits.

Test Plan:
- ADD 0x7FFFFFFF+1, reg_write_en_in=1 -> result=0x80000000, overflow_flag=1, reg_write_en_out=0. ADDU with the same operands -> overflow_flag=0, reg_write_en_out=1.
- SRA shamt=4, operand_2=0x80000000 -> result 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT with the same operands -> 0.
- MULT 0xFFFFFFFE × 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. Next cycle MFHI returns 0xFFFFFFFF.
- DIV -7 / 2 -> stall_request high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> stall_request high 1 cycle, then LO=0xFFFFFFFF, HI=5.
- DIV started, flush asserted at iteration 10 -> stall_request=0 the next cycle; HI/LO keep their prior values. Repeat with rst -> HI=LO=0.

Source files
------------

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, shifter, HI/LO registers, single-cycle multiplier
// and a 32-iteration restoring divider that stalls the pipeline while busy.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        reg_write_en_in,
    input  logic [4:0]  reg_write_addr_in,
    output logic [31:0] result,
    output logic        reg_write_en_out,
    output logic [4:0]  reg_write_addr_out,
    output logic        overflow_flag,
    output logic        stall_request,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    div_state_t        state, state_nx;
    logic [31:0]       hi_q, lo_q;
    logic [31:0]       div_quo, div_rem, div_dvsr;
    logic [CNT_W-1:0]  count;
    logic              neg_q, neg_r;
    logic              div_start, div_commit;

    logic [31:0] sum, diff, alu_res;
    logic        ovf;
    logic [63:0] prod_s, prod_u;
    logic [32:0] partial, trial;
    logic        is_div, signed_div;
    logic [31:0] abs_1, abs_2, q_fix, r_fix;

    assign sum    = operand_1 + operand_2;
    assign diff   = operand_1 - operand_2;
    assign prod_s = {{32{operand_1[31]}}, operand_1} * {{32{operand_2[31]}}, operand_2};
    assign prod_u = {32'd0, operand_1} * {32'd0, operand_2};

    // ALU, shifter and HI/LO read mux
    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (funct)
            FN_ADD: begin
                alu_res = sum;
                ovf     = (operand_1[31] == operand_2[31]) && (sum[31] != operand_1[31]);
            end
            FN_SUB: begin
                alu_res = diff;
                ovf     = (operand_1[31] != operand_2[31]) && (diff[31] != operand_1[31]);
            end
            FN_ADDU: alu_res = sum;
            FN_SUBU: alu_res = diff;
            FN_AND:  alu_res = operand_1 & operand_2;
            FN_OR:   alu_res = operand_1 | operand_2;
            FN_XOR:  alu_res = operand_1 ^ operand_2;
            FN_NOR:  alu_res = ~(operand_1 | operand_2);
            FN_SLT:  alu_res = {31'd0, $signed(operand_1) < $signed(operand_2)};
            FN_SLTU: alu_res = {31'd0, operand_1 < operand_2};
            FN_SLL:  alu_res = operand_2 << shamt;
            FN_SRL:  alu_res = operand_2 >> shamt;
            FN_SRA:  alu_res = $signed(operand_2) >>> shamt;
            FN_SLLV: alu_res = operand_2 << operand_1[4:0];
            FN_SRLV: alu_res = operand_2 >> operand_1[4:0];
            FN_SRAV: alu_res = $signed(operand_2) >>> operand_1[4:0];
            FN_MFHI: alu_res = hi_q;
            FN_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign result             = alu_res;
    assign overflow_flag      = ovf;
    assign reg_write_en_out   = reg_write_en_in & ~ovf;
    assign reg_write_addr_out = reg_write_addr_in;
    assign hi_out             = hi_q;
    assign lo_out             = lo_q;

    assign is_div     = (funct == FN_DIV) || (funct == FN_DIVU);
    assign signed_div = (funct == FN_DIV);
    assign abs_1      = (signed_div && operand_1[31]) ? (~operand_1 + 32'd1) : operand_1;
    assign abs_2      = (signed_div && operand_2[31]) ? (~operand_2 + 32'd1) : operand_2;
    assign partial    = {div_rem, div_quo[31]};
    assign trial      = partial - {1'b0, div_dvsr};
    assign q_fix      = neg_q ? (~div_quo + 32'd1) : div_quo;
    assign r_fix      = neg_r ? (~div_rem + 32'd1) : div_rem;

    // Divider next-state and stall request
    always_comb begin
        state_nx      = state;
        stall_request = 1'b0;
        div_start     = 1'b0;
        div_commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_div && !flush) begin
                    stall_request = 1'b1;
                    div_start     = 1'b1;
                    state_nx      = (operand_2 == 32'd0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                stall_request = 1'b1;
                if (count == CNT_W'(DIV_CYCLES - 1)) state_nx = S_DONE;
            end
            S_DONE: begin
                if (!stall && !flush) begin
                    div_commit = 1'b1;
                    state_nx   = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            div_quo  <= '0;
            div_rem  <= '0;
            div_dvsr <= '0;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            state <= state_nx;
            // A zero divisor preloads the architected divide-by-zero result
            if (div_start) begin
                count <= '0;
                if (operand_2 == 32'd0) begin
                    div_quo <= '1;
                    div_rem <= operand_1;
                    neg_q   <= 1'b0;
                    neg_r   <= 1'b0;
                end else begin
                    div_quo  <= abs_1;
                    div_rem  <= '0;
                    div_dvsr <= abs_2;
                    neg_q    <= signed_div && (operand_1[31] ^ operand_2[31]);
                    neg_r    <= signed_div && operand_1[31];
                end
            end else if (state == S_BUSY) begin
                count <= count + CNT_W'(1);
                if (!trial[32]) begin
                    div_rem <= trial[31:0];
                    div_quo <= {div_quo[30:0], 1'b1};
                end else begin
                    div_rem <= partial[31:0];
                    div_quo <= {div_quo[30:0], 1'b0};
                end
            end

            if (div_commit) begin
                lo_q <= q_fix;
                hi_q <= r_fix;
            end else if (state == S_IDLE && !stall && !flush) begin
                case (funct)
                    FN_MTHI:  hi_q <= operand_1;
                    FN_MTLO:  lo_q <= operand_1;
                    FN_MULT:  {hi_q, lo_q} <= prod_s;
                    FN_MULTU: {hi_q, lo_q} <= prod_u;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model of the
// ALU, HI/LO registers and divide timing.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst, flush, stall;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] operand_1, operand_2;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] result;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic        overflow_flag, stall_request;
    logic [31:0] hi_out, lo_out;

    ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .funct(funct), .shamt(shamt),
        .operand_1(operand_1), .operand_2(operand_2),
        .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
        .result(result), .reg_write_en_out(reg_write_en_out),
        .reg_write_addr_out(reg_write_addr_out), .overflow_flag(overflow_flag),
        .stall_request(stall_request), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [5:0] f, input logic [4:0] sh,
                                               input logic [31:0] a, input logic [31:0] b);
        longint sb;
        sb = longint'($signed(b));
        case (f)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            6'h00: return b * (32'd1 << sh);
            6'h02: return b / (32'd1 << sh);
            6'h03: return 32'(sb >>> sh);
            6'h04: return b * (32'd1 << a[4:0]);
            6'h06: return b / (32'd1 << a[4:0]);
            6'h07: return 32'(sb >>> a[4:0]);
            6'h10: return m_hi;
            6'h12: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint s;
        if (f == 6'h20)      s = longint'($signed(a)) + longint'($signed(b));
        else if (f == 6'h22) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // One non-divide instruction: inputs driven on the falling edge
    task automatic alu_op(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] a,
                          input logic [31:0] b, input logic wen, input logic st, input logic fl);
        logic [31:0] er;
        logic        eo;
        logic [4:0]  wa;
        longint      p;
        wa = 5'($urandom);
        funct = f; shamt = sh; operand_1 = a; operand_2 = b;
        reg_write_en_in = wen; reg_write_addr_in = wa; stall = st; flush = fl;
        #1;
        er = ref_result(f, sh, a, b);
        eo = ref_ovf(f, a, b);
        check("result", result, er);
        check("overflow", overflow_flag, eo);
        check("wen_out", reg_write_en_out, wen && !eo);
        check("waddr", reg_write_addr_out, wa);
        check("stall_req", stall_request, 1'b0);
        @(posedge clk);
        if (!st && !fl) begin
            case (f)
                6'h11: m_hi = a;
                6'h13: m_lo = a;
                6'h18: begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    {m_hi, m_lo} = p;
                end
                6'h19: begin
                    p = longint'({32'd0, a}) * longint'({32'd0, b});
                    {m_hi, m_lo} = p;
                end
                default: ;
            endcase
        end
        @(negedge clk);
        check("hi", hi_out, m_hi);
        check("lo", lo_out, m_lo);
    endtask

    // Divide: counts stall_request cycles; abort_at >= 0 flushes or resets at that cycle
    task automatic do_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input bit abort_rst, input bit done_stall);
        logic [31:0] eq, er;
        int          cnt;
        int          exp_cnt;
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF; er = a;
        end else if (f == 6'h1B) begin
            eq = a / b; er = a % b;
        end else begin
            eq = $signed(a) / $signed(b); er = $signed(a) % $signed(b);
        end
        exp_cnt = (b == 32'd0) ? 1 : 33;
        funct = f; operand_1 = a; operand_2 = b; shamt = '0;
        stall = 1'b0; flush = 1'b0; reg_write_en_in = 1'b0;
        cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (!stall_request) break;
            cnt++;
            if (cyc == abort_at) begin
                if (abort_rst) rst = 1'b1; else flush = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0; flush = 1'b0; funct = 6'h00;
                if (abort_rst) begin m_hi = '0; m_lo = '0; end
                @(negedge clk);
                check("abort_stall_req", stall_request, 1'b0);
                check("abort_hi", hi_out, m_hi);
                check("abort_lo", lo_out, m_lo);
                return;
            end
            @(negedge clk);
        end
        check("div_stall_cycles", 64'(cnt), 64'(exp_cnt));
        check("div_done_result", result, 32'd0);
        if (done_stall) begin
            stall = 1'b1;
            @(posedge clk);
            @(negedge clk);
            #1;
            check("done_hold_req", stall_request, 1'b0);
            check("done_hold_hi", hi_out, m_hi);
            check("done_hold_lo", lo_out, m_lo);
            stall = 1'b0;
        end
        @(posedge clk);
        m_lo = eq; m_hi = er;
        #1;
        funct = 6'h12;
        @(negedge clk);
        #1;
        check("div_hi", hi_out, m_hi);
        check("div_lo", lo_out, m_lo);
        check("mflo_after_div", result, m_lo);
        check("post_div_req", stall_request, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] ops [23] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                             6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19, 6'h3F};

    initial begin
        logic [31:0] a, b;
        logic [5:0]  f;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; funct = '0; shamt = '0;
        operand_1 = '0; operand_2 = '0; reg_write_en_in = 1'b0; reg_write_addr_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_result", result, 32'd0);
        check("reset_ovf", overflow_flag, 1'b0);
        check("reset_stall_req", stall_request, 1'b0);
        check("reset_wen", reg_write_en_out, 1'b0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);

        alu_op(6'h20, 5'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0);
        alu_op(6'h21, 5'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0);
        alu_op(6'h22, 5'd0, 32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0);
        alu_op(6'h03, 5'd4, 32'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        alu_op(6'h2B, 5'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        alu_op(6'h2A, 5'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        alu_op(6'h18, 5'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        check("mult_hi_const", hi_out, 32'hFFFF_FFFF);
        check("mult_lo_const", lo_out, 32'hFFFF_FFFA);
        alu_op(6'h10, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        alu_op(6'h11, 5'd0, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b0);
        alu_op(6'h13, 5'd0, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b1);

        do_div(6'h1A, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 1'b0);
        check("div_lo_const", lo_out, 32'hFFFF_FFFD);
        check("div_hi_const", hi_out, 32'hFFFF_FFFF);
        do_div(6'h1B, 32'd100, 32'd7, -1, 1'b0, 1'b1);
        check("divu_lo_const", lo_out, 32'd14);
        check("divu_hi_const", hi_out, 32'd2);
        do_div(6'h1B, 32'd5, 32'd0, -1, 1'b0, 1'b0);
        check("div0_lo_const", lo_out, 32'hFFFF_FFFF);
        check("div0_hi_const", hi_out, 32'd5);

        alu_op(6'h11, 5'd0, 32'hAAAA_0001, 32'd0, 1'b0, 1'b0, 1'b0);
        alu_op(6'h13, 5'd0, 32'h5555_0002, 32'd0, 1'b0, 1'b0, 1'b0);
        do_div(6'h1A, 32'd1000, 32'd3, 11, 1'b0, 1'b0);
        do_div(6'h1A, 32'd1000, 32'd3, 11, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            f = ops[$urandom_range(0, 22)];
            alu_op(f, 5'($urandom), pick_operand(), pick_operand(), 1'($urandom),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
        end

        for (int i = 0; i < 20; i++) begin
            a = pick_operand();
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : pick_operand();
            f = $urandom_range(0, 1) ? 6'h1A : 6'h1B;
            if (f == 6'h1A && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            do_div(f, a, b, -1, 1'b0, 1'($urandom));
            alu_op(6'h10, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
